freq_counter_lut: RTL and testbench
===================================

// Module: freq_counter_lut
// PURPOSE
//  Measures the period of square-wave RF input sig in clk cycles and converts it to frequency
//  in units of 100 Hz. Maps that frequency onto a 7-bit capacitor-state code via a fixed
//  79-corner table spanning 500..2996 (50..~300 kHz).
//  Feeds the series/parallel cap-board code outputs of the QCM master controller.
// PARAMETERS
//  CLK_HZ  40_000_000  clk frequency in Hz; K = CLK_HZ/100 is the dividend constant
//  PW      20          period counter width in bits (saturating)
//  KW      24          dividend width in bits; divider iterations; K must be < 2**KW
// PORTS
//  clk    in   1   system clock, all logic on rising edge
//  rst_n  in   1   asynchronous, active-low reset
//  sig    in   1   asynchronous square-wave RF input
//  freq   out  14  measured frequency, units of 100 Hz, saturating at 16383
//  state  out  7   capacitor state code, range 0..79
//  upd    out  1   one-cycle pulse, high in the cycle state takes a new value
// BEHAVIOUR
//  Reset (rst_n=0, async): freq=0, state=0, upd=0; counter, divider and pending regs cleared.
//   On release, normal operation resumes; asserting rst_n=0 mid-divide aborts the divide.
//  Input conditioning: sig passes through a 2-FF synchronizer.
//   A rising edge is detected on the synchronized signal (sync_q=1, prev=0).
//  Period counter (PW bits) increments every clk and saturates at 2**PW-1.
//   On a detected edge: capture period = counter value and reload counter to 1.
//   The first edge after reset is discarded; it only starts counting.
//  Timeout: when the counter reaches 2**PW-1, the block forces freq=0 and state=0 once.
//   upd pulses if state changed. No further updates occur until two edges have been seen.
//  Divider: sequential restoring, 1 quotient bit per cycle, KW cycles.
//   Computes q = floor(K/period). freq = min(q, 16383); period 0 never occurs.
//   Captured period starts the divider if idle; if busy, it goes to a 1-deep pending register.
//   A newer capture overwrites pending (latest wins); pending starts when the divide finishes.
//  Latency: freq written KW+1 cycles after the capture cycle; state registered 1 cycle later.
//  LUT (registered): corner[i] = 500 + 32*i, i=0..78.
//   state = 0 if freq < 500.
//   state = i+1 for corner[i] <= freq < corner[i+1].
//   state = 79 if freq >= 2996.
//  upd = 1 in the cycle state is loaded with a value different from its previous value, else 0.
//  freq and state are held stable between updates; no glitching between capture and update.
//  Edge arriving in the same cycle as saturation: the capture wins, and the period is 2**PW-1.
// TESTING  (CLK_HZ=40e6, PW=20, KW=24)
//  100 kHz sig (400-cycle period): after 2nd edge + latency, freq=1000, state=16, upd pulses once.
//  50 kHz sig (800 cycles) -> freq=500, state=1; 40 kHz (1000 cycles) -> freq=400, state=0.
//  250 kHz sig (160 cycles) -> freq=2500, state=63; steady input -> upd never re-pulses.
//  200 kHz sig (200 cycles) -> freq=2000, state=47; then sig held low > 2**20 cycles -> freq=0, state=0, upd pulses.
//  Period 10 cycles -> q=40000, freq saturates at 16383, state=79.
//  Edges every 20 cycles while divide busy -> results from latest periods only, no hang.
//  rst_n pulse mid-divide -> freq=0, state=0 immediately; recovers after 2 new edges.

Source files
------------

// File: rtl/freq_counter_lut.sv
// freq_counter_lut: measures the sig period, divides K/period to get freq in 100 Hz units, and maps it to a capacitor state code
//   clk   system clock          rst_n  async active-low reset
//   sig   async RF square wave  freq   frequency in 100 Hz units, saturating at 16383
//   state cap code 0..79        upd    one-cycle pulse when state changes
module freq_counter_lut #(
  parameter int CLK_HZ = 40_000_000,
  parameter int PW = 20,
  parameter int KW = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig,
  output logic [13:0] freq,
  output logic [6:0]  state,
  output logic        upd
);
  localparam logic [KW-1:0] K = KW'(CLK_HZ / 100);
  localparam logic [PW-1:0] MAX = '1;
  localparam int IW = $clog2(KW);
  typedef enum logic [1:0] {IDLE, DIV, DONE} st_t;
  st_t st, st_n;
  logic s1, s2, prev, seen, pend_v;
  logic edg, cap, tout, start_cap, start_pend, start, ge;
  logic [PW-1:0] cnt, pend, dvs, rem, dv_in;
  logic [PW:0] sh, nrem;
  logic [KW-1:0] quo;
  logic [IW-1:0] it;
  logic [13:0] off;
  logic [6:0] lut;
  assign edg = s2 & ~prev;
  // the first edge after reset or timeout only arms the counter
  assign cap = edg & seen;
  assign tout = (cnt == MAX) & ~edg & seen;
  // a finishing divide serves the pending period first; a fresh capture then queues
  assign start_pend = (st == DONE) & pend_v;
  assign start_cap = cap & ((st == IDLE) | ((st == DONE) & ~pend_v));
  assign start = start_pend | start_cap;
  assign dv_in = start_pend ? pend : cnt;
  assign sh = {rem, quo[KW-1]};
  assign ge = sh >= {1'b0, dvs};
  assign nrem = ge ? sh - {1'b0, dvs} : sh;
  assign off = freq - 14'd500;
  assign lut = freq < 14'd500 ? 7'd0 : freq >= 14'd2996 ? 7'd79 : 7'(off[13:5]) + 7'd1;
  always_comb begin
    st_n = st;
    if (tout) st_n = IDLE;
    else if (start) st_n = DIV;
    else if (st == DIV && it == IW'(KW - 1)) st_n = DONE;
    else if (st == DONE) st_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s1, s2, prev, seen, pend_v, upd} <= '0;
      st <= IDLE;
      cnt <= '0;
      pend <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      it <= '0;
      freq <= '0;
      state <= '0;
    end else begin
      s1 <= sig;
      s2 <= s1;
      prev <= s2;
      st <= st_n;
      cnt <= edg ? PW'(1) : cnt == MAX ? cnt : cnt + PW'(1);
      seen <= tout ? 1'b0 : edg ? 1'b1 : seen;
      if (cap && !start_cap) begin
        pend <= cnt;
        pend_v <= 1'b1;
      end else if (start_pend || tout) pend_v <= 1'b0;
      if (start) begin
        dvs <= dv_in;
        rem <= '0;
        quo <= K;
        it <= '0;
      end else if (st == DIV) begin
        rem <= nrem[PW-1:0];
        quo <= {quo[KW-2:0], ge};
        it <= it + IW'(1);
      end
      if (tout) freq <= '0;
      else if (st == DONE) freq <= |quo[KW-1:14] ? 14'h3fff : quo[13:0];
      state <= lut;
      upd <= lut != state;
    end
  end
endmodule

// File: tb/tb_freq_counter_lut.sv
// tb_freq_counter_lut: randomized and directed checks of freq_counter_lut against a division/table reference model
module tb_freq_counter_lut;
  logic clk = 0, rst_n = 0, sig = 0;
  logic [13:0] freq, freq_s;
  logic [6:0] state, state_s;
  logic upd, upd_s;
  int n_cmp = 0, n_bad = 0, n_upd = 0, n_upd_s = 0;
  always #5 clk = ~clk;
  freq_counter_lut dut (.clk(clk), .rst_n(rst_n), .sig(sig), .freq(freq), .state(state), .upd(upd));
  // short counter instance so saturation/timeout fits in a short run
  freq_counter_lut #(.PW(12)) dut_s (.clk(clk), .rst_n(rst_n), .sig(sig), .freq(freq_s), .state(state_s), .upd(upd_s));
  always @(negedge clk) begin
    if (upd) n_upd++;
    if (upd_s) n_upd_s++;
  end
  function automatic int ref_freq(int p);
    int q = 400000 / p;
    return q > 16383 ? 16383 : q;
  endfunction
  function automatic int ref_state(int f);
    int s = 0;
    for (int i = 0; i < 79; i++) if (f >= 500 + 32 * i) s = i + 1;
    return s;
  endfunction
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic gen(int p, int n);
    for (int i = 0; i < n; i++) begin
      sig = 1;
      cyc(p / 2);
      sig = 0;
      cyc(p - p / 2);
    end
  endtask
  task automatic test_reset;
    rst_n = 0;
    cyc(3);
    n_cmp++; if (freq !== 14'd0) begin n_bad++; $display("FAIL rst_freq got %0d exp 0", freq); end
    n_cmp++; if (state !== 7'd0) begin n_bad++; $display("FAIL rst_state got %0d exp 0", state); end
    n_cmp++; if (upd !== 1'b0) begin n_bad++; $display("FAIL rst_upd got %0b exp 0", upd); end
    n_cmp++; if (freq_s !== 14'd0 || state_s !== 7'd0) begin n_bad++; $display("FAIL rst_small got %0d/%0d exp 0/0", freq_s, state_s); end
    rst_n = 1;
    cyc(2);
  endtask
  task automatic test_single;
    n_upd = 0;
    gen(400, 4);
    cyc(40);
    n_cmp++; if (freq !== 14'd1000) begin n_bad++; $display("FAIL single_freq got %0d exp 1000", freq); end
    n_cmp++; if (state !== 7'd16) begin n_bad++; $display("FAIL single_state got %0d exp 16", state); end
    n_cmp++; if (n_upd != 1) begin n_bad++; $display("FAIL single_upd pulses got %0d exp 1", n_upd); end
  endtask
  task automatic test_steady;
    gen(160, 3);
    n_upd = 0;
    gen(160, 6);
    cyc(40);
    n_cmp++; if (freq !== 14'd2500 || state !== 7'd63) begin n_bad++; $display("FAIL steady got %0d/%0d exp 2500/63", freq, state); end
    n_cmp++; if (n_upd != 0) begin n_bad++; $display("FAIL steady_upd pulses got %0d exp 0", n_upd); end
  endtask
  task automatic test_directed;
    int pl[10] = '{800, 1000, 200, 10, 134, 133, 752, 751, 400, 160};
    foreach (pl[k]) begin
      int ef = ref_freq(pl[k]);
      int es = ref_state(ef);
      gen(pl[k], 3);
      cyc(40);
      n_cmp++; if (freq !== 14'(ef)) begin n_bad++; $display("FAIL dir_freq p=%0d got %0d exp %0d", pl[k], freq, ef); end
      n_cmp++; if (state !== 7'(es)) begin n_bad++; $display("FAIL dir_state p=%0d got %0d exp %0d", pl[k], state, es); end
    end
  endtask
  task automatic test_timeout;
    gen(200, 4);
    cyc(40);
    n_cmp++; if (freq_s !== 14'd2000 || state_s !== 7'd47) begin n_bad++; $display("FAIL to_pre got %0d/%0d exp 2000/47", freq_s, state_s); end
    n_upd_s = 0;
    cyc(5000);
    n_cmp++; if (freq_s !== 14'd0 || state_s !== 7'd0) begin n_bad++; $display("FAIL to_zero got %0d/%0d exp 0/0", freq_s, state_s); end
    n_cmp++; if (n_upd_s != 1) begin n_bad++; $display("FAIL to_upd pulses got %0d exp 1", n_upd_s); end
    n_cmp++; if (freq !== 14'd2000 || state !== 7'd47) begin n_bad++; $display("FAIL to_hold got %0d/%0d exp 2000/47", freq, state); end
    gen(200, 1);
    cyc(40);
    n_cmp++; if (freq_s !== 14'd0) begin n_bad++; $display("FAIL to_one_edge got %0d exp 0", freq_s); end
    gen(200, 3);
    cyc(40);
    n_cmp++; if (freq_s !== 14'd2000 || state_s !== 7'd47) begin n_bad++; $display("FAIL to_recover got %0d/%0d exp 2000/47", freq_s, state_s); end
  endtask
  task automatic test_sat_edge;
    gen(4095, 2);
    sig = 1;
    cyc(100);
    sig = 0;
    n_cmp++; if (freq_s !== 14'(ref_freq(4095))) begin n_bad++; $display("FAIL sat_edge got %0d exp %0d", freq_s, ref_freq(4095)); end
    cyc(4200);
    n_cmp++; if (freq_s !== 14'd0 || state_s !== 7'd0) begin n_bad++; $display("FAIL sat_over got %0d/%0d exp 0/0", freq_s, state_s); end
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 30; i++) gen($urandom_range(24, 10), 1);
    cyc(60);
    n_cmp++; if (freq !== 14'd16383 || state !== 7'd79) begin n_bad++; $display("FAIL b2b_burst got %0d/%0d exp 16383/79", freq, state); end
    gen(400, 4);
    cyc(40);
    n_cmp++; if (freq !== 14'd1000 || state !== 7'd16) begin n_bad++; $display("FAIL b2b_after got %0d/%0d exp 1000/16", freq, state); end
  endtask
  task automatic test_mid_reset;
    fork
      gen(400, 6);
      begin
        cyc(10);
        n_cmp++; if (freq !== 14'd1000) begin n_bad++; $display("FAIL mr_pre got %0d exp 1000", freq); end
        rst_n = 0;
        #1;
        n_cmp++; if (freq !== 14'd0 || state !== 7'd0 || upd !== 1'b0) begin n_bad++; $display("FAIL mr_async got %0d/%0d/%0b exp 0/0/0", freq, state, upd); end
        cyc(2);
        rst_n = 1;
        cyc(300);
        n_cmp++; if (freq !== 14'd0) begin n_bad++; $display("FAIL mr_wait got %0d exp 0", freq); end
      end
    join
    cyc(40);
    n_cmp++; if (freq !== 14'd1000 || state !== 7'd16) begin n_bad++; $display("FAIL mr_recover got %0d/%0d exp 1000/16", freq, state); end
  endtask
  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      int p = $urandom_range(600, 12);
      int ef = ref_freq(p);
      int es = ref_state(ef);
      gen(p, 4);
      cyc(40);
      n_cmp++; if (freq !== 14'(ef) || state !== 7'(es)) begin n_bad++; $display("FAIL rnd p=%0d got %0d/%0d exp %0d/%0d", p, freq, state, ef, es); end
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_steady;
    test_directed;
    test_timeout;
    test_sat_edge;
    test_back_to_back;
    test_mid_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
